rr_grant_fsm: RTL and testbench

Round-robin grant controller that shares one single-owner resource (e.g. an FSM-driven datapath unit) among N requesters. Explicit 3-state machine (IDLE/BUSY/GAP) arbitrates pending requests, holds the grant until the owner signals done, and inserts a programmable idle gap before the next arbitration. Sits between requester ports and the shared unit; its grant vector drives the unit's input mux and enable.

---
 rtl/rr_grant_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_rr_grant_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_fsm.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_fsm
// Purpose  : Round-robin grant controller that shares one single-owner
//            resource among N requesters. A three-state machine
//            (IDLE/BUSY/GAP) arbitrates pending requests, holds the grant
//            until the owner signals done, then inserts a programmable idle
//            gap before the next arbitration.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N           number of requesters (2..8)
//   GAP_CYCLES  idle cycles after a release before arbitration resumes (0..15)
//   MAX_HOLD    maximum BUSY cycles before a forced release (1..255);
//               only meaningful when the timeout feature is built in
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   req[N]      level-sensitive request per requester
//   done[N]     release strobe per requester (only the owner's bit counts)
//   gnt[N]      registered one-hot grant
//   gnt_valid   registered OR of gnt
//   gnt_id      index of the current owner; holds the last owner when idle
//   state_o     IDLE=0, BUSY=1, GAP=2
//   timeout     one-cycle pulse following a forced release
// Build option
//   RR_GRANT_FSM_TIMEOUT_EN  when defined, an 8-bit hold counter forces a
//                            release after MAX_HOLD cycles in BUSY; when
//                            undefined, BUSY lasts until done and timeout
//                            is constant 0.
// ============================================================================
module rr_grant_fsm #(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic [1:0]           state_o,
  output logic                 timeout
);

  localparam int IDW = $clog2(N);

  // Gap counter load value; counting down to zero gives GAP_CYCLES cycles.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;       // last winner; search starts just after it
  logic [3:0]     gap_cnt;

  logic [IDW-1:0] win_id;
  logic [N-1:0]   win_onehot;
  logic           owner_done;
  logic           hold_expired;
  logic           release_now;

  // --------------------------------------------------------------------------
  // Round-robin pick: first set request scanning p+1, p+2, ... modulo N.
  // The last candidate examined is p itself, so a lone requester that just
  // owned the resource can win again.
  // --------------------------------------------------------------------------
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IDW-1:0] p);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = p;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(p) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
    return pick;
  endfunction

  always_comb begin
    win_id = rr_pick(req, ptr);
  end

  always_comb begin
    win_onehot         = '0;
    win_onehot[win_id] = 1'b1;
  end

  // Only the current owner's done bit is honoured; other bits are ignored.
  assign owner_done  = done[gnt_id];
  assign release_now = (state == BUSY) && (owner_done || hold_expired);

  // --------------------------------------------------------------------------
  // Main controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= IDW'(N - 1);   // requester 0 gets first priority
      gap_cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // With no requests nothing changes, outputs included.
          if (|req) begin
            state     <= BUSY;
            gnt       <= win_onehot;
            gnt_valid <= 1'b1;
            gnt_id    <= win_id;
            ptr       <= win_id;
          end
        end

        BUSY: begin
          // The owner dropping req does not release; only done or a timeout.
          if (release_now) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gap_cnt   <= GAP_LOAD;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end

        GAP: begin
          // Requests are not looked at until the gap has fully elapsed.
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        default: begin
          // Encoding 3 is unreachable; recover to a clean idle.
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

  // --------------------------------------------------------------------------
  // Optional hold-time limit
  // --------------------------------------------------------------------------
`ifdef RR_GRANT_FSM_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic       timeout_q;

  // Counter is 0 on the first BUSY cycle, so reaching MAX_HOLD-1 means the
  // grant has been held for MAX_HOLD cycles.
  assign hold_expired = (state == BUSY) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            hold_cnt <= 8'd0;
          end
        end
        BUSY: begin
          // A done in the same cycle as expiry is an ordinary release.
          if (!owner_done) begin
            if (hold_expired) begin
              timeout_q <= 1'b1;
            end else if (hold_cnt != 8'hFF) begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  // Feature compiled out: timeout is constant low; MAX_HOLD has no effect.
  assign timeout      = (MAX_HOLD < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rr_grant_fsm
// Purpose  : Self-checking bench for rr_grant_fsm. Three instances share the
//            clock and reset: GAP_CYCLES = 1 (main), 0 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_fsm;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] id;
    logic [1:0] st;
    logic       to;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_a   [3];
  logic [3:0] done_a  [3];
  logic [3:0] gnt_a   [3];
  logic       valid_a [3];
  logic [1:0] id_a    [3];
  logic [1:0] st_a    [3];
  logic       to_a    [3];

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  rr_grant_fsm #(.N(4), .GAP_CYCLES(1), .MAX_HOLD(16)) u_dut (
    .clk(clk), .reset(reset), .req(req_a[0]), .done(done_a[0]),
    .gnt(gnt_a[0]), .gnt_valid(valid_a[0]), .gnt_id(id_a[0]),
    .state_o(st_a[0]), .timeout(to_a[0])
  );

  rr_grant_fsm #(.N(4), .GAP_CYCLES(0), .MAX_HOLD(16)) u_gap0 (
    .clk(clk), .reset(reset), .req(req_a[1]), .done(done_a[1]),
    .gnt(gnt_a[1]), .gnt_valid(valid_a[1]), .gnt_id(id_a[1]),
    .state_o(st_a[1]), .timeout(to_a[1])
  );

  rr_grant_fsm #(.N(4), .GAP_CYCLES(3), .MAX_HOLD(16)) u_gap3 (
    .clk(clk), .reset(reset), .req(req_a[2]), .done(done_a[2]),
    .gnt(gnt_a[2]), .gnt_valid(valid_a[2]), .gnt_id(id_a[2]),
    .state_o(st_a[2]), .timeout(to_a[2])
  );

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] d,
                              input logic [3:0] g, input logic v,
                              input logic [1:0] i, input logic [1:0] s,
                              input logic t);
    vec_t x;
    x.req = r; x.done = d; x.gnt = g; x.valid = v; x.id = i; x.st = s; x.to = t;
    return x;
  endfunction

  task automatic check(input string name, input int sel, input vec_t e);
    total++;
    if (gnt_a[sel] !== e.gnt || valid_a[sel] !== e.valid || id_a[sel] !== e.id ||
        st_a[sel] !== e.st || to_a[sel] !== e.to) begin
      bad++;
      $display("FAIL %s (dut %0d): got gnt=%b valid=%b id=%0d state=%0d timeout=%b, want gnt=%b valid=%b id=%0d state=%0d timeout=%b",
               name, sel, gnt_a[sel], valid_a[sel], id_a[sel], st_a[sel], to_a[sel],
               e.gnt, e.valid, e.id, e.st, e.to);
    end
  endtask

  // Drive one vector at the falling edge, queue its expectation, compare
  // just after the next rising edge.
  task automatic step(input string name, input int sel, input vec_t v);
    @(negedge clk);
    req_a[sel]  = v.req;
    done_a[sel] = v.done;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check(name, sel, sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one;
    logic [3:0] oh;
    logic [3:0] nb;
    int         o;

    one = 4'b0001;
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      req_a[s]  = 4'b0;
      done_a[s] = 4'b0;
    end

    // ---- table: idle after reset, then full round robin with req=1111 ----
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    end
    for (int k = 0; k < 5; k++) begin
      o  = k % 4;
      oh = one << o;
      nb = one << ((o + 1) % 4);
      tbl.push_back(mk(4'hF, 4'h0, oh,   1'b1, 2'(o), 2'd1, 1'b0)); // grant
      tbl.push_back(mk(4'hF, nb,   oh,   1'b1, 2'(o), 2'd1, 1'b0)); // non-owner done
      tbl.push_back(mk(4'hF, oh,   4'h0, 1'b0, 2'(o), 2'd2, 1'b0)); // release
      tbl.push_back(mk(4'hF, 4'h0, 4'h0, 1'b0, 2'(o), 2'd0, 1'b0)); // gap over
    end

    @(posedge clk);
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check("reset_values", s, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step("table_rr", 0, tbl[i]);
    end

    // ---- grant held through req drop and foreign done ----
    step("hold_grant",   0, mk(4'h4, 4'h0, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));
    step("hold_c1",      0, mk(4'h4, 4'h0, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));
    step("hold_reqdrop", 0, mk(4'h0, 4'h0, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));
    step("hold_c3",      0, mk(4'h0, 4'h0, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));
    step("hold_foreign", 0, mk(4'h0, 4'h1, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));
    step("hold_c5",      0, mk(4'h0, 4'h0, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));
    step("hold_release", 0, mk(4'h0, 4'h4, 4'h0, 1'b0, 2'd2, 2'd2, 1'b0));
    step("gap_no_sample",0, mk(4'h3, 4'h0, 4'h0, 1'b0, 2'd2, 2'd0, 1'b0));
    step("wrap_to_0",    0, mk(4'h3, 4'h0, 4'h1, 1'b1, 2'd0, 2'd1, 1'b0));
    step("wrap_rel",     0, mk(4'h3, 4'h1, 4'h0, 1'b0, 2'd0, 2'd2, 1'b0));
    step("wrap_gap",     0, mk(4'h3, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    step("next_is_1",    0, mk(4'h3, 4'h0, 4'h2, 1'b1, 2'd1, 2'd1, 1'b0));
    step("rel_1",        0, mk(4'h0, 4'h2, 4'h0, 1'b0, 2'd1, 2'd2, 1'b0));
    step("gap_1",        0, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 2'd0, 1'b0));
    step("idle_hold",    0, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 2'd0, 1'b0));

    // ---- hold limit: owner 1 never signals done ----
    step("to_grant", 0, mk(4'h2, 4'h0, 4'h2, 1'b1, 2'd1, 2'd1, 1'b0));
    for (int j = 1; j < 16; j++) begin
      step("to_busy", 0, mk(4'h2, 4'h0, 4'h2, 1'b1, 2'd1, 2'd1, 1'b0));
    end
`ifdef RR_GRANT_FSM_TIMEOUT_EN
    step("to_forced",   0, mk(4'h2, 4'h0, 4'h0, 1'b0, 2'd1, 2'd2, 1'b1));
    step("to_pulse_end",0, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 2'd0, 1'b0));
`else
    step("no_to_busy",  0, mk(4'h2, 4'h0, 4'h2, 1'b1, 2'd1, 2'd1, 1'b0));
    step("no_to_rel",   0, mk(4'h0, 4'h2, 4'h0, 1'b0, 2'd1, 2'd2, 1'b0));
    step("no_to_gap",   0, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 2'd0, 1'b0));
`endif
    // done arrives on the very cycle the limit is reached: plain release
    step("tie_grant", 0, mk(4'h2, 4'h0, 4'h2, 1'b1, 2'd1, 2'd1, 1'b0));
    for (int j = 1; j < 16; j++) begin
      step("tie_busy", 0, mk(4'h2, 4'h0, 4'h2, 1'b1, 2'd1, 2'd1, 1'b0));
    end
    step("tie_done_wins", 0, mk(4'h2, 4'h2, 4'h0, 1'b0, 2'd1, 2'd2, 1'b0));
    step("tie_gap",       0, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 2'd0, 1'b0));

    // ---- asynchronous reset while owner 2 holds the grant ----
    step("rst_grant2", 0, mk(4'h4, 4'h0, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));
    step("rst_busy",   0, mk(4'h4, 4'h0, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));
    @(negedge clk);
    #2;
    reset = 1'b1;
    req_a[0] = 4'h0;
    #1;
    check("async_reset", 0, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    step("post_rst_idle", 0, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    step("post_rst_ptr",  0, mk(4'hC, 4'h0, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));

    // ---- GAP_CYCLES = 0: BUSY -> IDLE -> BUSY ----
    step("g0_grant",  1, mk(4'h1, 4'h0, 4'h1, 1'b1, 2'd0, 2'd1, 1'b0));
    step("g0_rel",    1, mk(4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    step("g0_regrant",1, mk(4'h1, 4'h0, 4'h1, 1'b1, 2'd0, 2'd1, 1'b0));
    step("g0_rel2",   1, mk(4'h0, 4'h1, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));

    // ---- GAP_CYCLES = 3: exactly three GAP cycles ----
    step("g3_grant", 2, mk(4'h4, 4'h0, 4'h4, 1'b1, 2'd2, 2'd1, 1'b0));
    step("g3_rel",   2, mk(4'h0, 4'h4, 4'h0, 1'b0, 2'd2, 2'd2, 1'b0));
    step("g3_gap2",  2, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd2, 2'd2, 1'b0));
    step("g3_gap3",  2, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd2, 2'd2, 1'b0));
    step("g3_idle",  2, mk(4'h0, 4'h0, 4'h0, 1'b0, 2'd2, 2'd0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
